rejection_sampler: RTL
======================

# rejection_sampler

Sequential front end for the generated constraint checker: produces pseudo-random packed candidate vectors, presents them to the checker's variable inputs, and samples the checker's single `x` result. Candidates for which `x` is high are accepted into a small output FIFO with a valid/ready interface, until the requested number of samples is collected or a retry limit expires. The checker stays purely combinational. This block owns all state: LFSRs, attempt counting, buffering and completion.

## Interface
Parameters:
- `VEC_W`, default 384: packed candidate width (sum of checker variable widths, var_0 in LSBs).
- `FIFO_DEPTH`, default 4: accepted-sample buffer depth; power of two, at least 2.
- `MAX_TRIES`, default 1024: consecutive rejected candidates before timeout.
- `SEED`, default 32'h1: base LFSR seed.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: begin a run; sampled only in IDLE, DONE or TIMEOUT.
- `n_samples`, in, 16: samples to collect; latched on `start`.
- `cand`, out, VEC_W: current candidate, driven to the checker. Registered.
- `chk_ok`, in, 1: checker `x` for the current `cand`, same cycle.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: consumer accepts head when high with `out_valid`.
- `out_data`, out, VEC_W: FIFO head.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: sticky; high in DONE until the next accepted `start` or `rst`.
- `timeout`, out, 1: sticky; high in TIMEOUT until the next accepted `start` or `rst`.
- `tries`, out, 32: total candidates evaluated in the current run.

## Operation
- Candidates come from ceil(VEC_W/32) parallel 32-bit Galois LFSRs with polynomial 32'h80200003.
  - LFSR i seed: `SEED ^ (i * 32'h9E3779B9)`; a zero result is replaced by 1.
  - `cand` is the concatenation of the LFSRs, truncated to VEC_W.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE/DONE/TIMEOUT to RUN on `start` with `n_samples` != 0. This clears the accept count, reject count and `tries`. LFSRs are not reseeded.
  - `start` with `n_samples` == 0 goes directly to DONE.
  - RUN, each cycle:
    - FIFO full: stall. LFSRs hold, nothing counted.
    - Else `chk_ok`=1: push `cand`, increment accepts, clear the reject count.
    - Else: increment the reject count.
    - Any non-stall cycle: increment `tries` and advance the LFSRs.
  - RUN to DONE when the accept count reaches the latched `n_samples` (on that push cycle).
  - RUN to TIMEOUT when the reject count reaches MAX_TRIES.
  - `start` in RUN is ignored.
- The FIFO keeps draining in every state. Samples remaining after DONE or TIMEOUT stay readable.
- A push and a pop in the same cycle are both allowed. When full, a same-cycle pop does not unstall; the stall is evaluated on registered full.
- `tries` saturates at 32'hFFFFFFFF.

## Timing
- One attempt per non-stalled cycle. `chk_ok` is combinational from registered `cand`; the accept decision registers at the next edge.
- Accepted `cand` appears on `out_data`/`out_valid` one cycle after the accept edge when the FIFO was empty.
- `done`/`timeout` rise in the cycle after the final push or final reject. `busy` falls at the same edge.
- Reset values:
  - `cand` = seed concatenation.
  - `out_valid`, `busy`, `done`, `timeout` = 0.
  - `tries` = 0; FIFO empty; state IDLE.
- `rst` mid-run aborts immediately: FIFO contents are discarded and the LFSRs reseed.

## Configuration
- `SAMPLER_DEDUP_EN` defined: keep a register of the last accepted candidate.
  - A `chk_ok`=1 candidate equal to it counts as a reject.
  - Register validity clears on `rst` and on an accepted `start`.
- Undefined: every `chk_ok`=1 candidate is accepted; no compare register.

## Structure
- `sampler_pkg` holds:
  - the FSM state enum;
  - the LFSR polynomial 32'h80200003;
  - the seed-spread constant 32'h9E3779B9;
  - the seed derivation function.
- One sub-module, `sampler_lfsr32`: single Galois LFSR with `clk`, `rst`, `en`, a seed parameter and a 32-bit state output; instantiated by generate loop.
- The FIFO is inline: a register array plus pointers with an extra wrap bit.

## Test plan
- `start`, `n_samples`=0: `done`=1 one cycle later; `out_valid` never high; `tries`=0.
- Stub `chk_ok`=`cand[0]`, `n_samples`=3, `out_ready`=1: exactly 3 outputs, each with bit0=1; `done` after the third accept; `tries` equals the count of cycles spent in RUN.
- `chk_ok`=1, `out_ready`=0, `n_samples`=8:
  - exactly 4 accepts, then `cand` frozen and `tries`=4;
  - after `out_ready`=1, 4 more accepts and `done`; outputs arrive in accept order.
- `chk_ok`=0, MAX_TRIES=16: `timeout`=1 after 16 attempts, `busy`=0, `done`=0, `tries`=16.
- `rst` pulse mid-run after 5 accepts: all outputs at reset values, FIFO empty. A restart gives a first `cand` identical to the first `cand` of the original run.
- `SAMPLER_DEDUP_EN`: force the LFSR state to repeat (bench `force` on `cand`, `chk_ok`=1); the second identical candidate is rejected and the accept count is unchanged.

Source files
------------

// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared FSM states, LFSR constants and seed derivation for rejection_sampler
package sampler_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam logic [31:0] LFSR_POLY   = 32'h80200003;
    localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] base, input logic [31:0] idx);
        logic [31:0] s;
        s = base ^ (idx * SEED_SPREAD);
        if (s == 32'h0) begin
            s = 32'h1;
        end
        return s;
    endfunction

endpackage

// File: rtl/sampler_lfsr32.sv
// rtl/sampler_lfsr32.sv - single 32-bit Galois LFSR (right shift) with enable and parameter seed
module sampler_lfsr32 #(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] state
);
    import sampler_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/rejection_sampler.sv
// rtl/rejection_sampler.sv - LFSR candidate generator, accept FIFO and run control; SAMPLER_DEDUP_EN rejects repeats of the last accept
module rejection_sampler #(
    parameter int          VEC_W      = 384,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_TRIES  = 1024,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      n_samples,
    output logic [VEC_W-1:0] cand,
    input  logic             chk_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      tries
);
    import sampler_pkg::*;

    localparam int NUM_LFSR = (VEC_W + 31) / 32;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int RW       = $clog2(MAX_TRIES + 1);

    state_t               state, state_nx;
    logic [NUM_LFSR*32-1:0] lfsr_cat;
    logic                 unused_lfsr;
    logic [15:0]          n_lat, acc_cnt;
    logic [RW-1:0]        rej_cnt;
    logic [VEC_W-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, start_ok, attempt, dup, accept, reject, pop;

    genvar g;
    generate
        for (g = 0; g < NUM_LFSR; g++) begin : g_lfsr
            sampler_lfsr32 #(
                .SEED(lfsr_seed(SEED, 32'(g)))
            ) u_lfsr (
                .clk  (clk),
                .rst  (rst),
                .en   (attempt),
                .state(lfsr_cat[g*32 +: 32])
            );
        end
    endgenerate

    assign cand        = lfsr_cat[VEC_W-1:0];
    assign unused_lfsr = ^lfsr_cat;

    // Stall uses registered full so a same-cycle pop cannot release it.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign pop       = out_valid && out_ready;

    assign start_ok = start && (state != S_RUN);
    assign attempt  = (state == S_RUN) && !full;
    assign accept   = attempt && chk_ok && !dup;
    assign reject   = attempt && !accept;

`ifdef SAMPLER_DEDUP_EN
    logic [VEC_W-1:0] last_acc;
    logic             last_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_acc <= '0;
            last_vld <= 1'b0;
        end else if (start_ok) begin
            last_vld <= 1'b0;
        end else if (accept) begin
            last_acc <= cand;
            last_vld <= 1'b1;
        end
    end

    assign dup = last_vld && (cand == last_acc);
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN: begin
                if (accept && (acc_cnt + 16'd1 == n_lat)) begin
                    state_nx = S_DONE;
                end else if (reject && (rej_cnt + RW'(1) == RW'(MAX_TRIES))) begin
                    state_nx = S_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_nx = (n_samples == 16'd0) ? S_DONE : S_RUN;
                end
            end
        endcase
    end

    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign timeout = (state == S_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            n_lat   <= 16'd0;
            acc_cnt <= 16'd0;
            rej_cnt <= '0;
            tries   <= 32'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                n_lat   <= n_samples;
                acc_cnt <= 16'd0;
                rej_cnt <= '0;
                tries   <= 32'd0;
            end else begin
                if (attempt && (tries != 32'hFFFF_FFFF)) begin
                    tries <= tries + 32'd1;
                end
                if (accept) begin
                    acc_cnt <= acc_cnt + 16'd1;
                    rej_cnt <= '0;
                end else if (reject) begin
                    rej_cnt <= rej_cnt + RW'(1);
                end
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= cand;
        end
    end

endmodule
